ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same ps2_clk/ps2_data lines the receiver listens on.
- Generates the request-to-send sequence, then shifts out start, 8 data bits (LSB first), odd parity and stop bits on device-generated clock edges.
- Checks the device ACK bit.
- Lines are open-drain; this block only pulls low or releases. The top level ties the outputs to tri-state pads.
- Sits beside ps2_keyboard; the top level holds the receiver in clear (clrn low) while busy is 1.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum clk cycles from clock release to ACK (15 ms at 50 MHz).
- SYNC_STAGES, 3, synchronizer depth on ps2_clk/ps2_data inputs (minimum 2).

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- tx_data  in  8  byte to send; sampled when a start is accepted
- tx_start  in  1  single-cycle request; accepted only when busy is 0
- ps2_clk  in  1  PS/2 clock line as seen at pad
- ps2_data  in  1  PS/2 data line as seen at pad
- ps2_clk_low  out  1  1 = pull ps2_clk low, 0 = release
- ps2_data_low  out  1  1 = pull ps2_data low, 0 = release
- busy  out  1  1 from accept cycle until done/ack_err/timeout pulse
- done  out  1  one-cycle pulse: byte sent and ACK seen
- ack_err  out  1  one-cycle pulse: ACK bit sampled high
- timeout  out  1  one-cycle pulse: TIMEOUT_CYCLES expired

Behaviour:
- Reset (async, clrn=0): state IDLE; all outputs 0; lines released; counters cleared. Reset mid-transfer releases both lines immediately and drops any pending byte.
- Inputs pass through SYNC_STAGES flops. A falling edge is a synchronized 1->0 transition of ps2_clk, detected once per edge.
- Frame register is 11 bits, loaded on accept: {stop=1, parity=~^tx_data, tx_data, start=0}. Bit index counts 0..10.
- IDLE: tx_start=1 -> latch frame, busy<=1, go to INHIBIT next cycle. tx_start while busy is ignored.
- INHIBIT: ps2_clk_low=1; count INHIBIT_CYCLES, then go to REQ.
- REQ: ps2_data_low=1 (start bit) with ps2_clk_low still 1 for exactly 1 cycle. Then ps2_clk_low<=0, timeout counter cleared, go to SEND with bit index=1.
- SEND: on each falling edge, ps2_data_low <= ~frame[idx], idx++.
  - Edges 1-8 present data bits 0-7; edge 9 presents parity; edge 10 presents stop (line released).
  - After edge 10 go to ACK.
- ACK: on next falling edge sample synchronized ps2_data. 0 -> go to WAIT_REL. 1 -> ack_err pulse, go to IDLE.
- WAIT_REL: wait until synced ps2_clk=1 and ps2_data=1, then done pulse, busy<=0, IDLE.
- Timeout: counter runs in SEND, ACK and WAIT_REL. At TIMEOUT_CYCLES: release both lines, timeout pulse, busy<=0, IDLE. If timeout coincides with ACK sampling, timeout wins.
- busy falls in the same cycle as the terminating pulse. A new tx_start is accepted on the following cycle.
- No line is ever driven high. ps2_clk_low is 1 only in INHIBIT and REQ.

Decomposition:
- Shared package ps2_pkg: state encoding constants (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_REL), frame width 11, PS/2 command constants (8'hED, 8'hFF, 8'hF4, 8'hFA ack-byte).
- Sub-module ps2_edge_sync: synchronizer plus falling-edge pulse. It is reusable by ps2_keyboard.

Test Plan:
- 0xED, device model clocking at 12.5 kHz and ACKing -> ps2_clk_low high for 5000 cycles; data bits sampled on device rising edges = 0,1,0,1,1,0,1,1,1,1,1 (start, bits LSB first, parity 1, stop); done pulse; busy low.
- 0x07 -> parity bit 0 observed; 0x00 -> parity bit 1 observed.
- Device leaves ps2_data high at ACK clock -> ack_err=1 for one cycle, done=0, both lines released.
- Device never clocks after release -> timeout pulse exactly TIMEOUT_CYCLES after REQ exit; both drive outputs 0.
- clrn pulled low after 4th data edge -> ps2_clk_low=ps2_data_low=busy=0 asynchronously. A fresh 0xF4 after reset completes with done.
- tx_start asserted again while busy with 0xFF -> ignored; the first byte (0xED) completes unaltered.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame geometry and command bytes.
package ps2_pkg;

    localparam int unsigned FRAME_W = 11;
    localparam int unsigned IDX_W   = 4;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_REL
    } ps2_tx_state_e;

    // {stop, odd parity, data, start}; bit 0 goes out first
    function automatic logic [FRAME_W-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Synchronizes the PS/2 clock and data pads and flags each ps2_clk falling edge once.
module ps2_edge_sync #(
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o
);

    logic [SYNC_STAGES-1:0] clk_sr_q;
    logic [SYNC_STAGES-1:0] data_sr_q;
    logic                   fall_q;

    // Idle lines float high, so reset to 1 to avoid a spurious edge after reset
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sr_q  <= '1;
            data_sr_q <= '1;
            fall_q    <= 1'b0;
        end else begin
            clk_sr_q  <= {clk_sr_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sr_q <= {data_sr_q[SYNC_STAGES-2:0], ps2_data_i};
            fall_q    <= clk_sr_q[SYNC_STAGES-1] & ~clk_sr_q[SYNC_STAGES-2];
        end
    end

    assign clk_sync_o  = clk_sr_q[SYNC_STAGES-1];
    assign data_sync_o = data_sr_q[SYNC_STAGES-1];
    assign clk_fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame on device clock, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_sync;
    logic data_sync;
    logic clk_fall;

    ps2_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .clk_fall_o  (clk_fall)
    );

    ps2_tx_state_e      state_q;
    logic [FRAME_W-1:0] frame_q;
    logic [IDX_W-1:0]   idx_q;
    logic [INH_W-1:0]   inh_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               clk_low_q;
    logic               data_low_q;
    logic               busy_q;
    logic               done_q;
    logic               ack_err_q;
    logic               timeout_q;
    logic               tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            idx_q      <= '0;
            inh_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_start) begin
                        frame_q   <= ps2_frame(tx_data);
                        busy_q    <= 1'b1;
                        clk_low_q <= 1'b1;
                        inh_cnt_q <= '0;
                        state_q   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                        data_low_q <= ~frame_q[0];
                        state_q    <= ST_REQ;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + INH_W'(1);
                    end
                end
                ST_REQ: begin
                    clk_low_q <= 1'b0;
                    tmo_cnt_q <= '0;
                    idx_q     <= IDX_W'(1);
                    state_q   <= ST_SEND;
                end
                ST_SEND, ST_ACK, ST_WAIT_REL: begin
                    // Timeout is checked first so it wins over a coincident ACK sample
                    if (tmo_hit) begin
                        clk_low_q  <= 1'b0;
                        data_low_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        case (state_q)
                            ST_SEND: begin
                                if (clk_fall) begin
                                    data_low_q <= ~frame_q[idx_q];
                                    idx_q      <= idx_q + IDX_W'(1);
                                    if (idx_q == IDX_W'(FRAME_W - 1)) begin
                                        state_q <= ST_ACK;
                                    end
                                end
                            end
                            ST_ACK: begin
                                if (clk_fall) begin
                                    if (!data_sync) begin
                                        state_q <= ST_WAIT_REL;
                                    end else begin
                                        ack_err_q <= 1'b1;
                                        busy_q    <= 1'b0;
                                        state_q   <= ST_IDLE;
                                    end
                                end
                            end
                            ST_WAIT_REL: begin
                                if (clk_sync && data_sync) begin
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= ST_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ps2_clk_low  = clk_low_q;
    assign ps2_data_low = data_low_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ack_err      = ack_err_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device plus a scoreboard of expected transfer outcomes.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INHIBIT = 64;
    localparam int unsigned TIMEOUT = 1500;
    localparam int          HALF    = 20;

    localparam int K_DONE = 1;
    localparam int K_NACK = 2;
    localparam int K_TMO  = 3;

    localparam int M_ACK   = 0;
    localparam int M_NACK  = 1;
    localparam int M_SILENT = 2;
    localparam int M_ABORT = 3;

    typedef struct {
        int          kind;
        logic [10:0] frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_start = 1'b0;
    logic        dev_clk = 1'b1;
    logic        dev_data = 1'b1;
    logic        ps2_clk_w;
    logic        ps2_data_w;
    logic        ps2_clk_low, ps2_data_low, busy, done, ack_err, timeout;

    logic [10:0] dev_frame = '0;
    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          inh_run = 0;
    logic        prev_clk_low = 1'b0;

    assign ps2_clk_w  = dev_clk & ~ps2_clk_low;
    assign ps2_data_w = dev_data & ~ps2_data_low;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (3)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .ps2_clk      (ps2_clk_w),
        .ps2_data     (ps2_data_w),
        .ps2_clk_low  (ps2_clk_low),
        .ps2_data_low (ps2_data_low),
        .busy         (busy),
        .done         (done),
        .ack_err      (ack_err),
        .timeout      (timeout)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every terminating pulse and tracks line timing
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (clrn) begin
            if (done || ack_err || timeout) begin
                kind = (int'(done) + int'(ack_err) + int'(timeout) != 1) ? 0 :
                       done ? K_DONE : ack_err ? K_NACK : K_TMO;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", kind, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("outcome_kind", kind, e.kind);
                    check("busy_at_end", int'(busy), 0);
                    check("lines_released", int'({ps2_clk_low, ps2_data_low}), 0);
                    if (e.kind == K_TMO)
                        check("timeout_latency", cyc - rel_cyc, int'(TIMEOUT));
                    else
                        check("device_frame", int'(dev_frame), int'(e.frame));
                end
            end
            if (prev_clk_low && !ps2_clk_low) rel_cyc = cyc;
            prev_clk_low = ps2_clk_low;
            if (ps2_clk_low && !ps2_data_low) begin
                inh_run++;
            end else begin
                if (ps2_clk_low && ps2_data_low && inh_run != 0)
                    check("inhibit_len", inh_run, int'(INHIBIT));
                inh_run = 0;
            end
        end else begin
            inh_run = 0;
            prev_clk_low = 1'b0;
        end
    end

    task automatic issue(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_half();
        repeat (HALF) @(negedge clk);
    endtask

    // Device model: waits for request-to-send, clocks the frame in, then answers the ACK slot
    task automatic device(input int mode);
        bit seen;
        seen = 1'b0;
        dev_frame = '0;
        for (int i = 0; i < int'(INHIBIT) + 50; i++) begin
            @(negedge clk);
            if (!ps2_clk_low && ps2_data_low) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("rts_seen", 0, 1);
            return;
        end
        if (mode == M_SILENT) return;
        dev_frame[0] = ps2_data_w;
        wait_half();
        for (int k = 1; k <= 10; k++) begin
            if (mode == M_ABORT && k == 5) return;
            dev_clk = 1'b0;
            wait_half();
            dev_clk = 1'b1;
            dev_frame[k] = ps2_data_w;
            wait_half();
        end
        if (mode == M_ACK) dev_data = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        wait_half();
        dev_clk = 1'b1;
        wait_half();
        dev_data = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < int'(TIMEOUT) + 400; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("busy_released", int'(busy), 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic run(input logic [7:0] d, input int mode, input int kind, input logic [10:0] f);
        exp_t e;
        e.kind  = kind;
        e.frame = f;
        exp_q.push_back(e);
        issue(d);
        device(mode);
        wait_idle();
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        check("rst_clk_low", int'(ps2_clk_low), 0);
        check("rst_data_low", int'(ps2_data_low), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pulses", int'({done, ack_err, timeout}), 0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", int'({ps2_clk_low, ps2_data_low, busy}), 0);

        run(PS2_CMD_SET_LEDS, M_ACK, K_DONE, 11'h7DA);
        run(8'h07, M_ACK, K_DONE, 11'h40E);
        check("parity_07", int'(dev_frame[9]), 0);
        run(8'h00, M_ACK, K_DONE, 11'h600);
        check("parity_00", int'(dev_frame[9]), 1);
        run(PS2_CMD_SET_LEDS, M_NACK, K_NACK, 11'h7DA);
        run(PS2_CMD_RESET, M_SILENT, K_TMO, 11'h000);

        // Reset in the middle of the data bits: lines must drop without a clock edge
        issue(8'h00);
        device(M_ABORT);
        check("busy_before_rst", int'(busy), 1);
        check("data_low_before_rst", int'(ps2_data_low), 1);
        #3 clrn = 1'b0;
        #1;
        check("async_rst_clk_low", int'(ps2_clk_low), 0);
        check("async_rst_data_low", int'(ps2_data_low), 0);
        check("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (5) @(negedge clk);
        run(PS2_CMD_ENABLE, M_ACK, K_DONE, 11'h5E8);

        // Second start while busy must not disturb the byte in flight
        e.kind  = K_DONE;
        e.frame = 11'h7DA;
        exp_q.push_back(e);
        issue(PS2_CMD_SET_LEDS);
        repeat (3) @(negedge clk);
        check("busy_during_tx", int'(busy), 1);
        issue(PS2_CMD_RESET);
        device(M_ACK);
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
